// File: rtl/mixer_pkg.sv
// +----------------------------------------------------------------------------+
// | mixer_pkg : shared types and width helpers for the voice mixer.            |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mixer_state_t;

    // Extra zero MSB so the unsigned gain stays positive in a signed multiply.
    localparam int GAIN_SIGN_PAD = 1;

    function automatic int calc_out_width(input int sw, input int gw, input int gf, input int nv);
        return sw + gw - gf + $clog2(nv);
    endfunction

    function automatic int calc_idx_width(input int nv);
        return (nv > 1) ? $clog2(nv) : 1;
    endfunction

    function automatic int calc_prod_width(input int sw, input int gw);
        return sw + gw + GAIN_SIGN_PAD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mixer_mac.sv
// +----------------------------------------------------------------------------+
// | mixer_mac : registered gain multiply / floor shift / mask and accumulator. |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mixer_mac
    import mixer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int GAIN_FRAC    = 7,
    parameter int OUT_WIDTH    = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           load,
    input  logic                           active,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic        [GAIN_WIDTH-1:0]   gain,
    output logic signed [OUT_WIDTH-1:0]    acc
);

    localparam int PROD_WIDTH = calc_prod_width(SAMPLE_WIDTH, GAIN_WIDTH);
    localparam int MULT_WIDTH = (PROD_WIDTH > OUT_WIDTH) ? PROD_WIDTH : OUT_WIDTH;

    logic signed [MULT_WIDTH-1:0] sample_ext;
    logic signed [MULT_WIDTH-1:0] gain_ext;
    logic signed [OUT_WIDTH-1:0]  prod_d, prod_q;
    logic signed [OUT_WIDTH-1:0]  acc_d, acc_q;
    logic                         prod_vld_d, prod_vld_q;

    always_comb begin
        sample_ext = MULT_WIDTH'(sample);
        gain_ext   = $signed(MULT_WIDTH'(gain));
        prod_d     = prod_q;
        prod_vld_d = load;
        // The shifted product always fits OUT_WIDTH, so the narrowing cast is lossless.
        if (load) begin
            prod_d = active ? OUT_WIDTH'((sample_ext * gain_ext) >>> GAIN_FRAC) : '0;
        end
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + prod_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/voice_mixer.sv
// +----------------------------------------------------------------------------+
// | voice_mixer : time-multiplexed gain-weighted sum of all drum voices.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int GAIN_FRAC    = 7,
    parameter int OUT_WIDTH    = calc_out_width(SAMPLE_WIDTH, GAIN_WIDTH, GAIN_FRAC, NUM_VOICES)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sample_req,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_samples,
    input  logic [NUM_VOICES*GAIN_WIDTH-1:0]     voice_gains,
    input  logic [NUM_VOICES-1:0]                voice_active,
    output logic signed [OUT_WIDTH-1:0]          mix_out,
    output logic                                 mix_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int             IDX_WIDTH = calc_idx_width(NUM_VOICES);
    localparam [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_VOICES - 1);

    mixer_state_t                       state_d, state_q;
    logic [IDX_WIDTH-1:0]               idx_d, idx_q;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_d, samples_q;
    logic [NUM_VOICES*GAIN_WIDTH-1:0]   gains_d, gains_q;
    logic [NUM_VOICES-1:0]              active_d, active_q;
    logic signed [OUT_WIDTH-1:0]        mix_out_d, mix_out_q;
    logic                               mix_valid_d, mix_valid_q;
    logic                               overrun_d, overrun_q;
    logic                               mac_clear, mac_load;
    logic signed [OUT_WIDTH-1:0]        mac_acc;

    logic signed [SAMPLE_WIDTH-1:0] sample_arr [NUM_VOICES];
    logic        [GAIN_WIDTH-1:0]   gain_arr   [NUM_VOICES];

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_unpack
        assign sample_arr[i] = samples_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign gain_arr[i]   = gains_q[i*GAIN_WIDTH +: GAIN_WIDTH];
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        samples_d   = samples_q;
        gains_d     = gains_q;
        active_d    = active_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = sample_req && busy;
        mac_clear   = 1'b0;
        mac_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_req) begin
                    samples_d = voice_samples;
                    gains_d   = voice_gains;
                    active_d  = voice_active;
                    idx_d     = '0;
                    mac_clear = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                mac_load = 1'b1;
                idx_d    = idx_q + IDX_WIDTH'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            // The last product is added into the accumulator on this edge.
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                mix_out_d   = mac_acc;
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            samples_q   <= '0;
            gains_q     <= '0;
            active_q    <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            samples_q   <= samples_d;
            gains_q     <= gains_d;
            active_q    <= active_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    mixer_mac #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .GAIN_WIDTH   (GAIN_WIDTH),
        .GAIN_FRAC    (GAIN_FRAC),
        .OUT_WIDTH    (OUT_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .load   (mac_load),
        .active (active_q[idx_q]),
        .sample (sample_arr[idx_q]),
        .gain   (gain_arr[idx_q]),
        .acc    (mac_acc)
    );

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire
